// File: rtl/spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_responder
// Description : SPI mode-0 responder giving an external microcontroller
//               read/write access to an 8-entry byte register window.
//               All SPI pins are oversampled in the clk28 domain. Writes leave
//               as a one-cycle strobe; reads fetch through rd_addr/rd_data.
//               Optional feature macro: SPI_RESPONDER_AUTOINC_EN (burst
//               address auto-increment after every data byte).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_responder (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       spi_cs_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       wr_strobe,
  output logic [2:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [2:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  // Status/sync byte presented on MISO while the command byte is received.
  localparam logic [7:0] c_sync_byte = 8'hA5;

`ifdef SPI_RESPONDER_AUTOINC_EN
  localparam logic c_autoinc = 1'b1;
`else
  localparam logic c_autoinc = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMD   = 2'd1,
    S_WRITE = 2'd2,
    S_READ  = 2'd3
  } state_t;

  // [0]/[1] are the synchroniser flops, [2] is the edge-detect history.
  logic [2:0] r_cs_sync;
  logic [2:0] r_sck_sync;
  // MOSI is only sampled, never edge-detected, so it needs no history stage.
  logic [1:0] r_mosi_sync;

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx;
  logic [7:0] r_shreg;
  logic [2:0] r_addr;
  logic       r_load_pend;

  logic       w_sck_rise;
  logic       w_sck_fall;
  logic       w_cs_fall;
  logic       w_cs_high;
  logic       w_mosi;
  logic [7:0] w_rx_byte;
  logic       w_byte_done;
  logic [2:0] w_next_addr;

  // Bring the asynchronous SPI pins into the clk28 domain.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_sync   <= 3'b111;
      r_sck_sync  <= 3'b000;
      r_mosi_sync <= 2'b00;
    end else begin
      r_cs_sync   <= {r_cs_sync[1:0], spi_cs_n};
      r_sck_sync  <= {r_sck_sync[1:0], spi_sck};
      r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
    end
  end

  assign w_sck_rise  = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_sck_fall  = ~r_sck_sync[1] & r_sck_sync[2];
  assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];
  assign w_cs_high   = r_cs_sync[1];
  assign w_mosi      = r_mosi_sync[1];
  assign w_rx_byte   = {r_rx[6:0], w_mosi};
  assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7);
  assign w_next_addr = c_autoinc ? (r_addr + 3'd1) : r_addr;

  assign spi_miso    = r_shreg[7];

  // Frame state machine: command decode, write strobes, read reloads, MISO shifting.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 3'd0;
      r_rx        <= 8'h00;
      r_shreg     <= c_sync_byte;
      r_addr      <= 3'd0;
      r_load_pend <= 1'b0;
      spi_miso_oe <= 1'b0;
      busy        <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_addr     <= 3'd0;
      wr_data     <= 8'h00;
      rd_addr     <= 3'd0;
    end else begin
      wr_strobe   <= 1'b0;
      r_load_pend <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            r_state     <= S_CMD;
            r_bit_cnt   <= 3'd0;
            r_shreg     <= c_sync_byte;
            spi_miso_oe <= 1'b1;
            busy        <= 1'b1;
          end
        end
        default: begin
          if (w_cs_high) begin
            // Deselect wins over any simultaneous SCK edge; a partial byte is dropped.
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            spi_miso_oe <= 1'b0;
            busy        <= 1'b0;
          end else begin
            // rd_data is valid the cycle after rd_addr moves; the byte-ending
            // fall (bit counter back at 0) must not shift the fresh byte away.
            if (r_load_pend) begin
              r_shreg <= rd_data;
            end else if (w_sck_fall && (r_bit_cnt != 3'd0)) begin
              r_shreg <= {r_shreg[6:0], 1'b0};
            end

            if (w_sck_rise) begin
              r_rx      <= w_rx_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_byte_done) begin
              case (r_state)
                S_CMD: begin
                  r_addr <= w_rx_byte[2:0];
                  if (w_rx_byte[7]) begin
                    r_state     <= S_READ;
                    rd_addr     <= w_rx_byte[2:0];
                    r_load_pend <= 1'b1;
                  end else begin
                    r_state <= S_WRITE;
                  end
                end
                S_WRITE: begin
                  wr_strobe <= 1'b1;
                  wr_addr   <= r_addr;
                  wr_data   <= w_rx_byte;
                  r_addr    <= w_next_addr;
                end
                S_READ: begin
                  r_addr      <= w_next_addr;
                  rd_addr     <= w_next_addr;
                  r_load_pend <= 1'b1;
                end
                default: begin
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spi_responder
// Description : Self-checking bench for spi_responder. Drives SPI mode-0
//               frames as a master, models the register window at frame/byte
//               level and compares strobes, MISO bytes and rd_addr.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_responder;

`ifdef SPI_RESPONDER_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk28;
  logic       rst_n;
  logic       spi_cs_n;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       wr_strobe;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;

  logic [7:0]  regs [8];
  logic [10:0] strobes [$];
  logic [7:0]  tx_q [$];

  int n_checks = 0;
  int n_errors = 0;

  assign rd_data = regs[rd_addr];

  spi_responder dut (
    .clk28       (clk28),
    .rst_n       (rst_n),
    .spi_cs_n    (spi_cs_n),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy)
  );

  initial clk28 = 1'b0;
  always #5 clk28 = ~clk28;

  // Record every strobed write; a strobe held two cycles shows up twice.
  always @(negedge clk28) begin
    if (rst_n && wr_strobe) strobes.push_back({wr_addr, wr_data});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  // Shift nbits of one byte MSB first; MISO is captured just before each rise.
  task automatic spi_byte(input logic [7:0] mo, input int nbits, input int h,
                          output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[7-i];
      repeat (h) @(negedge clk28);
      mi[7-i] = spi_miso;
      spi_sck = 1'b1;
      repeat (h) @(negedge clk28);
      spi_sck = 1'b0;
    end
  endtask

  // One complete frame: command byte then tx_q data bytes, checked against
  // the register-window model (reads return regs[a], writes strobe {a, d}).
  task automatic run_frame(input logic [7:0] cmd, input int h, input string tag);
    logic [7:0]  mi;
    logic [2:0]  a;
    logic [10:0] exp_q [$];
    strobes.delete();
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk28);
    chk({tag, "_oe"}, {31'd0, spi_miso_oe}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    spi_byte(cmd, 8, h, mi);
    chk({tag, "_sync_byte"}, {24'd0, mi}, 32'h0000_00A5);
    a = cmd[2:0];
    if (cmd[7]) chk({tag, "_rd_addr_cmd"}, {29'd0, rd_addr}, {29'd0, a});
    foreach (tx_q[i]) begin
      spi_byte(tx_q[i], 8, h, mi);
      if (cmd[7]) begin
        chk({tag, "_rd_byte"}, {24'd0, mi}, {24'd0, regs[a]});
        if (AUTOINC) a = a + 3'd1;
        chk({tag, "_rd_addr"}, {29'd0, rd_addr}, {29'd0, a});
      end else begin
        exp_q.push_back({a, tx_q[i]});
        if (AUTOINC) a = a + 3'd1;
      end
    end
    repeat (h) @(negedge clk28);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk28);
    chk({tag, "_oe_end"}, {31'd0, spi_miso_oe}, 32'd0);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({tag, "_n_strobe"}, strobes.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < strobes.size(); i++)
      chk({tag, "_strobe"}, {21'd0, strobes[i]}, {21'd0, exp_q[i]});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_miso"}, {31'd0, spi_miso}, 32'd1);
    chk({tag, "_oe"}, {31'd0, spi_miso_oe}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_wr_strobe"}, {31'd0, wr_strobe}, 32'd0);
    chk({tag, "_wr_addr"}, {29'd0, wr_addr}, 32'd0);
    chk({tag, "_wr_data"}, {24'd0, wr_data}, 32'd0);
    chk({tag, "_rd_addr"}, {29'd0, rd_addr}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mi;
    logic [7:0] cmd;
    int h;
    rst_n    = 1'b0;
    spi_cs_n = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = 8'h10 + 8'(i);
    repeat (4) @(negedge clk28);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk28);

    // Directed write frame: 0x03, 0x5A.
    tx_q = '{8'h5A};
    run_frame(8'h03, 4, "wr");
    chk("wr_addr_hold", {29'd0, wr_addr}, 32'd3);
    chk("wr_data_hold", {24'd0, wr_data}, 32'h5A);

    // Directed read burst: command 0x86 and three dummy bytes.
    tx_q = '{8'h00, 8'h00, 8'h00};
    run_frame(8'h86, 5, "rd");

    // Abort: write command then CS high after 5 bits of the data byte.
    strobes.delete();
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk28);
    spi_byte(8'h01, 8, 4, mi);
    spi_byte(8'hFF, 5, 4, mi);
    repeat (4) @(negedge clk28);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk28);
    chk("abort_n_strobe", strobes.size(), 0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_oe", {31'd0, spi_miso_oe}, 32'd0);
    chk("abort_wr_addr", {29'd0, wr_addr}, 32'd3);
    chk("abort_wr_data", {24'd0, wr_data}, 32'h5A);

    // Reset in the middle of a read data byte.
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk28);
    spi_byte(8'h85, 8, 4, mi);
    spi_byte(8'h00, 3, 4, mi);
    repeat (2) @(negedge clk28);
    #2 rst_n = 1'b0;
    #2 check_reset_outputs("midrst");
    spi_cs_n = 1'b1;
    spi_sck  = 1'b0;
    repeat (4) @(negedge clk28);
    rst_n = 1'b1;
    repeat (4) @(negedge clk28);
    tx_q = '{8'hC3};
    run_frame(8'h02, 4, "post_rst");

    // Maximum-rate four-byte write burst.
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(8'h06, 4, "maxrate");

    // Randomised frames.
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
      cmd = 8'($urandom);
      h   = $urandom_range(4, 6);
      tx_q.delete();
      for (int i = 0; i < $urandom_range(1, 4); i++) tx_q.push_back(8'($urandom));
      run_frame(cmd, h, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
